// File: rtl/interp_rate_ctrl.sv
// interp_rate_ctrl: one-deep sample buffer plus fixed-rate load scheduler for
// the interpolator. Issues one sample every OSR clocks and repeats the last
// sample when the source starves.
module interp_rate_ctrl #(
  parameter int unsigned OSR       = 8,
  parameter int unsigned VIN_BITS  = 15,
  parameter int unsigned UNDER_LIM = 4,
  localparam int unsigned CNT_W    = $clog2(OSR)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [VIN_BITS-1:0] s_data,
  output logic                load,
  output logic [VIN_BITS-1:0] v_out,
  output logic [CNT_W-1:0]    phase,
  output logic                running,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam int unsigned MISS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [VIN_BITS-1:0] smp_q, smp_d;
  logic                smp_full_q, smp_full_d;
  logic                load_q, load_d;
  logic [VIN_BITS-1:0] v_out_q, v_out_d;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic                underrun_q, underrun_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                accept, boundary, miss_lim, ur_set;

  // Ready never depends on s_valid, and is low while the buffer is occupied
  // so an accept can never collide with a load out of the buffer.
  assign s_ready  = !smp_full_q && !reset;
  assign accept   = s_valid && s_ready;
  assign boundary = (phase_q == CNT_W'(OSR - 1));
  assign miss_lim = (miss_q == MISS_W'(UNDER_LIM));

  assign load     = load_q;
  assign v_out    = v_out_q;
  assign phase    = phase_q;
  assign running  = (state_q == ST_RUN);
  assign underrun = underrun_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; RUN leaves only at a period boundary or after the
  // starvation limit has been counted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_PRIME;
      ST_PRIME: begin
        if (!enable)         state_d = ST_IDLE;
        else if (smp_full_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (miss_lim)                 state_d = ST_PRIME;
        else if (boundary && !enable) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath/output next values: buffer fill, load strobe, phase, misses
  always_comb begin
    smp_d      = smp_q;
    smp_full_d = smp_full_q;
    load_d     = 1'b0;
    v_out_d    = v_out_q;
    phase_d    = phase_q;
    miss_d     = miss_q;
    ur_set     = 1'b0;

    if (accept) begin
      smp_d      = s_data;
      smp_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: phase_d = '0;
      ST_PRIME: begin
        phase_d = '0;
        if (enable && smp_full_q) begin
          load_d     = 1'b1;
          v_out_d    = smp_q;
          smp_full_d = 1'b0;
          miss_d     = '0;
        end
      end
      ST_RUN: begin
        phase_d = phase_q + CNT_W'(1);
        if (miss_lim) begin
          phase_d = '0;
          miss_d  = '0;
        end else if (boundary && enable) begin
          load_d = 1'b1;
          if (smp_full_q) begin
            v_out_d    = smp_q;
            smp_full_d = 1'b0;
            miss_d     = '0;
          end else begin
            ur_set = 1'b1;
            if (!miss_lim) miss_d = miss_q + MISS_W'(1);
          end
        end
      end
      default: phase_d = '0;
    endcase

    // A fresh underrun wins over a simultaneous clear
    if (ur_set)            underrun_d = 1'b1;
    else if (underrun_clr) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      smp_q      <= '0;
      smp_full_q <= 1'b0;
      load_q     <= 1'b0;
      v_out_q    <= '0;
      phase_q    <= '0;
      underrun_q <= 1'b0;
      miss_q     <= '0;
    end else begin
      smp_q      <= smp_d;
      smp_full_q <= smp_full_d;
      load_q     <= load_d;
      v_out_q    <= v_out_d;
      phase_q    <= phase_d;
      underrun_q <= underrun_d;
      miss_q     <= miss_d;
    end
  end

endmodule

// File: tb/tb_interp_rate_ctrl.sv
// Bench for interp_rate_ctrl: per-cycle vector table, then directed sequences
// with a load scoreboard (expected v_out queued when a sample is accepted).
module tb_interp_rate_ctrl;

  localparam int unsigned OSR   = 8;
  localparam int unsigned VB    = 15;
  localparam int unsigned NSAMP = 1000;

  logic          clock, reset, enable, s_valid, s_ready, underrun_clr;
  logic [VB-1:0] s_data, v_out;
  logic          load, running, underrun;
  logic [2:0]    phase;

  interp_rate_ctrl #(.OSR(OSR), .VIN_BITS(VB), .UNDER_LIM(4)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load(load), .v_out(v_out), .phase(phase), .running(running),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst, en, vld; logic [VB-1:0] dat; logic clr;
    logic e_load; logic [VB-1:0] e_v; logic [2:0] e_ph; logic e_run, e_ur, e_rdy;
  } vec_t;

  vec_t          vecs[21];
  logic [VB-1:0] exp_q[$];
  int            tests = 0, fails = 0;
  int            cyc = 0, n_loads = 0, last_load = -1, ld_before;
  logic          chk_per = 1'b0, acc_last = 1'b0;

  function automatic vec_t mk(logic rst, logic en, logic vld, logic [VB-1:0] dat, logic clr,
                              logic ld, logic [VB-1:0] v, int ph, logic run, logic ur, logic rdy);
    vec_t r;
    r.rst = rst; r.en = en; r.vld = vld; r.dat = dat; r.clr = clr;
    r.e_load = ld; r.e_v = v; r.e_ph = 3'(ph); r.e_run = run; r.e_ur = ur; r.e_rdy = rdy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: note any accept just before the edge, then score loads after it
  task automatic tick();
    logic          acc;
    logic [VB-1:0] dat;
    #2;
    acc = s_valid && s_ready;
    dat = s_data;
    @(posedge clock);
    #1;
    cyc++;
    acc_last = acc;
    if (acc) exp_q.push_back(dat);
    if (load === 1'b1) begin
      n_loads++;
      check("load_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("load_value", 32'(v_out), 32'(exp_q.pop_front()));
      if (chk_per && last_load >= 0) check("load_period", 32'(cyc - last_load), 32'(OSR));
      last_load = cyc;
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * OSR && phase != 3'(p); i++) tick();
    check("reach_phase", 32'(phase), 32'(p));
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
    tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; underrun_clr = 1'b0;

    // Reset, PRIME latency, back-to-back samples, one starved boundary
    vecs[0]  = mk(1, 0, 0, 15'h0,    0, 0, 15'h0,    0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 15'h0,    0, 0, 15'h0,    0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 15'h1234, 0, 0, 15'h0,    0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 15'h0F00, 0, 1, 15'h1234, 0, 1, 0, 1);
    vecs[4]  = mk(0, 1, 1, 15'h0F00, 0, 0, 15'h1234, 1, 1, 0, 0);
    for (int k = 5; k <= 10; k++) vecs[k] = mk(0, 1, 0, 15'h0, 0, 0, 15'h1234, k - 3, 1, 0, 0);
    vecs[11] = mk(0, 1, 0, 15'h0,    0, 1, 15'h0F00, 0, 1, 0, 1);
    for (int k = 12; k <= 18; k++) vecs[k] = mk(0, 1, 0, 15'h0, 0, 0, 15'h0F00, k - 11, 1, 0, 1);
    vecs[19] = mk(0, 1, 0, 15'h0,    0, 1, 15'h0F00, 0, 1, 1, 1);
    vecs[20] = mk(0, 1, 0, 15'h0,    0, 0, 15'h0F00, 1, 1, 1, 1);

    for (int i = 0; i < 21; i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; s_valid = vecs[i].vld;
      s_data = vecs[i].dat; underrun_clr = vecs[i].clr;
      if (i == 19) exp_q.push_back(15'h0F00);
      tick();
      check($sformatf("vec%0d_load", i),  32'(load),     32'(vecs[i].e_load));
      check($sformatf("vec%0d_vout", i),  32'(v_out),    32'(vecs[i].e_v));
      check($sformatf("vec%0d_phase", i), 32'(phase),    32'(vecs[i].e_ph));
      check($sformatf("vec%0d_run", i),   32'(running),  32'(vecs[i].e_run));
      check($sformatf("vec%0d_ur", i),    32'(underrun), 32'(vecs[i].e_ur));
      check($sformatf("vec%0d_ready", i), 32'(s_ready),  32'(vecs[i].e_rdy));
    end

    // Reset at phase 5 with a sample buffered
    s_valid = 1'b0;
    wait_phase(4);
    s_valid = 1'b1; s_data = 15'h0555;
    tick();
    s_valid = 1'b0;
    check("mid_phase5", 32'(phase), 32'd5);
    reset = 1'b1; enable = 1'b0;
    tick();
    exp_q.delete();
    check("rst_load", 32'(load), 32'd0);
    check("rst_vout", 32'(v_out), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_run", 32'(running), 32'd0);
    check("rst_ur", 32'(underrun), 32'd0);
    check("rst_ready_low", 32'(s_ready), 32'd0);
    tick();
    check("rst_ready_hold", 32'(s_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_ready_after", 32'(s_ready), 32'd1);

    // Continuous source: steady rate, exact period, no underrun
    do_reset();
    n_loads = 0; last_load = -1; chk_per = 1'b1;
    enable = 1'b1; s_valid = 1'b1; s_data = 15'($urandom);
    for (int c = 0; c < NSAMP * OSR + 64 && n_loads < NSAMP; c++) begin
      tick();
      if (acc_last) s_data = 15'($urandom);
    end
    check("cont_loads", 32'(n_loads), 32'(NSAMP));
    check("cont_no_underrun", 32'(underrun), 32'd0);
    chk_per = 1'b0;
    do_reset();

    // Starvation after 0x0100: four repeats, then back to PRIME
    n_loads = 0; last_load = -1; chk_per = 1'b1;
    enable = 1'b1; s_valid = 1'b1; s_data = 15'h0100;
    tick();
    s_valid = 1'b0;
    repeat (4) exp_q.push_back(15'h0100);
    for (int c = 0; c < 12 * OSR; c++) tick();
    chk_per = 1'b0;
    check("starve_loads", 32'(n_loads), 32'd5);
    check("starve_q_empty", 32'(exp_q.size()), 32'd0);
    check("starve_ur", 32'(underrun), 32'd1);
    check("starve_not_run", 32'(running), 32'd0);
    check("starve_vout", 32'(v_out), 32'h0100);
    s_valid = 1'b1; s_data = 15'h0200;
    tick();
    s_valid = 1'b0;
    tick();
    check("reprime_load", 32'(load), 32'd1);
    check("reprime_run", 32'(running), 32'd1);

    // Underrun set beats a same-cycle clear
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("ur_clr_alone", 32'(underrun), 32'd0);
    wait_phase(7);
    underrun_clr = 1'b1;
    exp_q.push_back(15'h0200);
    tick();
    check("ur_set_wins", 32'(underrun), 32'd1);
    check("ur_set_load", 32'(load), 32'd1);
    tick();
    underrun_clr = 1'b0;
    check("ur_clr_next", 32'(underrun), 32'd0);
    do_reset();

    // Enable dropped mid-period: stop at boundary, keep buffer, reload via PRIME
    enable = 1'b1; s_valid = 1'b1; s_data = 15'h0AAA;
    tick();
    s_data = 15'h0BBB;
    tick();
    tick();
    s_valid = 1'b0;
    wait_phase(3);
    enable = 1'b0;
    repeat (4) tick();
    check("dis_phase7", 32'(phase), 32'd7);
    ld_before = n_loads;
    tick();
    check("dis_no_load", 32'(load), 32'd0);
    check("dis_idle", 32'(running), 32'd0);
    check("dis_phase0", 32'(phase), 32'd0);
    check("dis_vout_hold", 32'(v_out), 32'h0AAA);
    check("dis_buf_kept", 32'(s_ready), 32'd0);
    repeat (5) tick();
    check("dis_quiet", 32'(n_loads), 32'(ld_before));
    enable = 1'b1;
    tick();
    tick();
    check("reen_load", 32'(load), 32'd1);
    check("reen_vout", 32'(v_out), 32'h0BBB);
    check("reen_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
